serial_subtractor_5bit: RTL and testbench

SERIAL_SUBTRACTOR_5BIT -- requirements
Module: serial_subtractor_5bit

---
 rtl/serial_subtractor_5bit.sv | 138 +++++++++++++
 tb/tb_serial_subtractor_5bit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_5bit.sv
// Bit-serial 5-bit subtractor: one full-subtractor cell, LSB first, one bit per clock.
// Result flags (D, Bout, V, Z) are loaded together on the last bit and held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one difference bit per edge, bits 0..4
// DONE  | one-cycle completion pulse; exit edge may accept the next start
module serial_subtractor_5bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Bin,
    output logic [4:0] D,
    output logic       Bout,
    output logic       V,
    output logic       Z,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] a_q, a_d;
    logic [4:0] b_q, b_d;
    logic [4:0] acc_q, acc_d;
    logic [4:0] d_q, d_d;
    logic [2:0] cnt_q, cnt_d;
    logic       br_q, br_d;
    logic       bout_q, bout_d;
    logic       v_q, v_d;
    logic       z_q, z_d;

    logic       a_bit;
    logic       b_bit;
    logic       d_bit;
    logic       br_next;
    logic [4:0] d_final;
    logic       accept;

    always_comb begin
        a_bit   = a_q[cnt_q];
        b_bit   = b_q[cnt_q];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        // difference bits shift in from the MSB so bit 0 lands in place after five steps
        d_final = {d_bit, acc_q[4:1]};
        // the DONE exit edge doubles as an IDLE acceptance edge, giving a 6-cycle cadence with start held
        accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                acc_d = d_final;
                br_d  = br_next;
                if (cnt_q == 3'd4) begin
                    d_d     = d_final;
                    bout_d  = br_next;
                    v_d     = (a_q[4] != b_q[4]) && (d_final[4] != a_q[4]);
                    z_d     = (d_final == 5'd0);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d     = A;
            b_d     = B;
            br_d    = Bin;
            cnt_d   = 3'd0;
            acc_d   = 5'd0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 5'd0;
            b_q     <= 5'd0;
            acc_q   <= 5'd0;
            cnt_q   <= 3'd0;
            br_q    <= 1'b0;
            d_q     <= 5'd0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_5bit.sv
// Self-checking bench for serial_subtractor_5bit: directed cases, random operations,
// back-to-back cadence and mid-run reset against an arithmetic reference model.
module tb_serial_subtractor_5bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic       Bin;
    logic [4:0] D;
    logic       Bout;
    logic       V;
    logic       Z;
    logic       busy;
    logic       done;

    int n_checks;
    int n_errors;
    logic [7:0] prev_res;

    serial_subtractor_5bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // returns {V, Z, Bout, D}
    function automatic logic [7:0] model(input int a, input int b, input int bin);
        int diff, sa, sb, sd, d;
        logic bo, v, z;
        diff = a - b - bin;
        d    = (diff + 64) % 32;
        bo   = (a < b + bin);
        sa   = (a >= 16) ? a - 32 : a;
        sb   = (b >= 16) ? b - 32 : b;
        sd   = sa - sb - bin;
        v    = (sd < -16) || (sd > 15);
        z    = (d == 0);
        return {v, z, bo, d[4:0]};
    endfunction

    function automatic logic [7:0] dut_res();
        return {V, Z, Bout, D};
    endfunction

    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic bin,
                          input bit repulse);
        logic [7:0] exp_res;
        int edges;
        bit seen;
        exp_res = model(int'(a), int'(b), int'(bin));
        @(negedge clk);
        start = 1'b1; A = a; B = b; Bin = bin;
        @(posedge clk); #1;
        check_val("busy_after_start", int'(busy), 1);
        @(negedge clk);
        start = 1'b0; A = 5'($urandom); B = 5'($urandom); Bin = 1'($urandom);
        edges = 0;
        seen = 1'b0;
        while (!seen && edges < 20) begin
            if (repulse && edges == 2) begin
                @(negedge clk);
                start = 1'b1; A = 5'd31; B = 5'd31; Bin = 1'b0;
            end
            if (repulse && edges == 3) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                check_val("busy_in_run", int'(busy), 1);
                check_val("hold_in_run", int'(dut_res()), int'(prev_res));
            end
        end
        check_val("done_seen", int'(seen), 1);
        check_val("latency", edges, 5);
        check_val("busy_done", int'(busy), 1);
        check_val("D", int'(D), int'(exp_res[4:0]));
        check_val("Bout", int'(Bout), int'(exp_res[5]));
        check_val("Z", int'(Z), int'(exp_res[6]));
        check_val("V", int'(V), int'(exp_res[7]));
        prev_res = exp_res;
        @(posedge clk); #1;
        check_val("done_pulse_end", int'(done), 0);
        check_val("idle_busy", int'(busy), 0);
        check_val("hold_idle", int'(dut_res()), int'(prev_res));
    endtask

    task automatic back_to_back();
        logic [4:0] oa[18];
        logic [4:0] ob[18];
        logic       obin[18];
        logic [7:0] exp_res;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            oa[i] = 5'($urandom); ob[i] = 5'($urandom); obin[i] = 1'($urandom);
            start = 1'b1; A = oa[i]; B = ob[i]; Bin = obin[i];
            @(posedge clk); #1;
            check_val("b2b_busy", int'(busy), 1);
            if (i % 6 == 5) begin
                exp_res = model(int'(oa[i-5]), int'(ob[i-5]), int'(obin[i-5]));
                check_val("b2b_done", int'(done), 1);
                check_val("b2b_res", int'(dut_res()), int'(exp_res));
                prev_res = exp_res;
            end else begin
                check_val("b2b_nodone", int'(done), 0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check_val("b2b_idle", int'(busy), 0);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        start = 1'b1; A = 5'd9; B = 5'd2; Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_D", int'(D), 0);
        check_val("rst_Z", int'(Z), 0);
        check_val("rst_flags", int'({V, Bout}), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = 8'd0;
        repeat (6) begin
            @(posedge clk); #1;
            check_val("no_done_after_rst", int'(done), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_res = 8'd0;
        rst = 1'b1; start = 1'b0; A = 5'd0; B = 5'd0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs", int'({busy, done, dut_res()}), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(5'd13, 5'd6, 1'b0, 1'b0);
        run_op(5'd3, 5'd5, 1'b0, 1'b0);
        run_op(5'd10, 5'd10, 1'b0, 1'b0);
        run_op(5'd15, 5'd16, 1'b0, 1'b0);
        run_op(5'd16, 5'd1, 1'b0, 1'b0);
        run_op(5'd0, 5'd0, 1'b1, 1'b1);

        reset_mid_run();
        run_op(5'd20, 5'd4, 1'b0, 1'b0);

        // reset wins over start on the same edge
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 5'd7; B = 5'd1;
        @(posedge clk); #1;
        check_val("rst_prio_busy", int'(busy), 0);
        check_val("rst_prio_res", int'(dut_res()), 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        prev_res = 8'd0;

        for (int k = 0; k < 24; k++) begin
            run_op(5'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        end

        back_to_back();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
